// File: rtl/dijkstra_axil_regs.sv
// dijkstra_axil_regs: AXI4-Lite slave holding four 32-bit configuration words with a per-write commit pulse.
// Define DIJKSTRA_AXIL_STATUS_EN to expose a read-only commit counter at byte address 0x10.
module dijkstra_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [31:0]                       cfg0_o,
  output logic [31:0]                       cfg1_o,
  output logic [31:0]                       cfg2_o,
  output logic [31:0]                       cfg3_o,
  output logic                              cfg_wr_o,
  output logic [1:0]                        cfg_idx_o
);

  logic        ready_en;
  logic        aw_held, w_held;
  logic [2:0]  aw_idx_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid, rvalid;
  logic [31:0] rdata;
  logic [31:0] regs [4];
  logic        cfg_wr;
  logic [1:0]  cfg_idx;

  logic        aw_hs, w_hs, ar_hs, commit, wr_en;
  logic [2:0]  wr_idx, rd_idx;
  logic [31:0] wr_data, rd_value, status_word;
  logic [3:0]  wr_strb;

  // Protection bits and byte offsets within a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = ready_en & ~aw_held & ~bvalid;
  assign S_AXI_WREADY  = ready_en & ~w_held & ~bvalid;
  assign S_AXI_ARREADY = ready_en & ~rvalid;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign cfg0_o        = regs[0];
  assign cfg1_o        = regs[1];
  assign cfg2_o        = regs[2];
  assign cfg3_o        = regs[3];
  assign cfg_wr_o      = cfg_wr;
  assign cfg_idx_o     = cfg_idx;

  assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
  // Commit on the edge where the later of address and data arrives, using held or live values.
  assign commit  = (aw_held | aw_hs) & (w_held | w_hs);
  assign wr_idx  = aw_held ? aw_idx_q : S_AXI_AWADDR[4:2];
  assign wr_data = w_held ? w_data_q : S_AXI_WDATA;
  assign wr_strb = w_held ? w_strb_q : S_AXI_WSTRB;
  assign wr_en   = commit & ~wr_idx[2] & (|wr_strb);
  assign rd_idx  = S_AXI_ARADDR[4:2];

`ifdef DIJKSTRA_AXIL_STATUS_EN
  logic [15:0] wr_count;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wr_count <= 16'h0;
    else if (wr_en) wr_count <= wr_count + 16'd1;
  end

  assign status_word = {16'h0, wr_count};
`else
  assign status_word = 32'h0;
`endif

  always_comb begin
    rd_value = 32'h0;
    if (!rd_idx[2]) rd_value = regs[rd_idx[1:0]];
    else if (rd_idx == 3'd4) rd_value = status_word;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= 3'd0;
      w_data_q <= 32'h0;
      w_strb_q <= 4'h0;
      bvalid   <= 1'b0;
      cfg_wr   <= 1'b0;
      cfg_idx  <= 2'd0;
      for (int i = 0; i < 4; i++) regs[i] <= 32'h0;
    end else begin
      ready_en <= 1'b1;
      cfg_wr   <= wr_en;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        if (wr_en) begin
          cfg_idx <= wr_idx[1:0];
          for (int b = 0; b < 4; b++)
            if (wr_strb[b]) regs[wr_idx[1:0]][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= S_AXI_AWADDR[4:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
        if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;
      end
    end
  end

  // Read data captures the pre-edge register value, so a same-edge write is not visible yet.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid <= 1'b0;
      rdata  <= 32'h0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_value;
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dijkstra_axil_regs.sv
// tb_dijkstra_axil_regs: randomized scoreboard bench for dijkstra_axil_regs.
// Honours DIJKSTRA_AXIL_STATUS_EN when computing expected status reads.
module tb_dijkstra_axil_regs;

`ifdef DIJKSTRA_AXIL_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b1;
  logic [4:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [4:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic [31:0] cfg0_o, cfg1_o, cfg2_o, cfg3_o;
  logic        cfg_wr_o;
  logic [1:0]  cfg_idx_o;

  int n_checks = 0;
  int n_pass = 0;
  bit rand_ready = 1'b0;

  logic [31:0] model_regs [4];
  int          model_count = 0;
  logic [31:0] r_q [$];
  logic [1:0]  b_q [$];
  logic [1:0]  wr_q [$];

  logic        prev_bvalid = 1'b0, prev_bready = 1'b0;
  logic        prev_rvalid = 1'b0, prev_rready = 1'b0;
  logic [31:0] prev_rdata = '0;

  dijkstra_axil_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .cfg0_o(cfg0_o), .cfg1_o(cfg1_o), .cfg2_o(cfg2_o), .cfg3_o(cfg3_o),
    .cfg_wr_o(cfg_wr_o), .cfg_idx_o(cfg_idx_o)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  function automatic logic [31:0] cfg_sel(input logic [1:0] idx);
    case (idx)
      2'd0: return cfg0_o;
      2'd1: return cfg1_o;
      2'd2: return cfg2_o;
      default: return cfg3_o;
    endcase
  endfunction

  // Reference model: a word array updated through a byte-lane mask.
  function automatic void model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx = int'(addr[4:2]);
    logic [31:0] mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    b_q.push_back(2'b00);
    if (idx < 4 && strb != 4'h0) begin
      model_regs[idx] = (model_regs[idx] & ~mask) | (data & mask);
      wr_q.push_back(2'(idx));
      model_count++;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    int idx = int'(addr[4:2]);
    if (idx < 4) return model_regs[idx];
    if (idx == 4 && STATUS_EN) return 32'(model_count % 65536);
    return 32'h0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    model_count = 0;
    r_q.delete(); b_q.delete(); wr_q.delete();
  endfunction

  task automatic check_cfg(input string tag);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("%s_cfg%0d", tag, i), cfg_sel(2'(i)), model_regs[i]);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response or commit pulse.
  always @(negedge ACLK) begin
    logic [31:0] exp_r;
    logic [1:0]  exp_b, exp_i;
    if (!ARESETN) begin
      prev_bvalid = 1'b0; prev_rvalid = 1'b0;
    end else begin
      if (prev_bvalid && !prev_bready) checkOutput("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
      if (prev_rvalid && !prev_rready) begin
        checkOutput("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
        checkOutput("rdata_stable", S_AXI_RDATA, prev_rdata);
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (b_q.size() == 0) checkOutput("unexpected_bresp", 32'd1, 32'd0);
        else begin
          exp_b = b_q.pop_front();
          checkOutput("bresp", 32'(S_AXI_BRESP), 32'(exp_b));
        end
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (r_q.size() == 0) checkOutput("unexpected_rdata", 32'd1, 32'd0);
        else begin
          exp_r = r_q.pop_front();
          checkOutput("rdata", S_AXI_RDATA, exp_r);
          checkOutput("rresp", 32'(S_AXI_RRESP), 32'd0);
        end
      end
      if (cfg_wr_o) begin
        if (wr_q.size() == 0) checkOutput("unexpected_cfg_wr", 32'd1, 32'd0);
        else begin
          exp_i = wr_q.pop_front();
          checkOutput("cfg_idx", 32'(cfg_idx_o), 32'(exp_i));
          checkOutput("cfg_commit_value", cfg_sel(cfg_idx_o), model_regs[exp_i]);
        end
      end
      prev_bvalid = S_AXI_BVALID; prev_bready = S_AXI_BREADY;
      prev_rvalid = S_AXI_RVALID; prev_rready = S_AXI_RREADY;
      prev_rdata  = S_AXI_RDATA;
    end
  end

  // Issues an optional write (W leading AW by w_lead cycles) and an optional read together.
  task automatic applyStimulus(input bit do_w, input logic [4:0] waddr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int w_lead, input bit do_r,
                               input logic [4:0] raddr);
    bit aw_pend, w_pend, ar_pend, aw_fire, w_fire, ar_fire;
    int cyc;
    if (do_r) r_q.push_back(model_read(raddr));
    if (do_w) model_write(waddr, wdata, wstrb);
    @(posedge ACLK); #1;
    aw_pend = do_w; w_pend = do_w; ar_pend = do_r;
    S_AXI_AWADDR = waddr; S_AXI_WDATA = wdata; S_AXI_WSTRB = wstrb; S_AXI_ARADDR = raddr;
    S_AXI_WVALID = do_w;
    S_AXI_AWVALID = do_w && (w_lead == 0);
    S_AXI_ARVALID = do_r;
    cyc = 0;
    while ((aw_pend || w_pend || ar_pend) && cyc < 100) begin
      @(negedge ACLK);
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
      if (do_w && cyc >= 1 && cyc <= w_lead) begin
        checkOutput("early_w_bvalid", 32'(S_AXI_BVALID), 32'd0);
        checkOutput("early_w_wready", 32'(S_AXI_WREADY), 32'd0);
      end
      @(posedge ACLK); #1;
      if (aw_fire) begin S_AXI_AWVALID = 1'b0; aw_pend = 1'b0; end
      if (w_fire)  begin S_AXI_WVALID = 1'b0;  w_pend = 1'b0;  end
      if (ar_fire) begin S_AXI_ARVALID = 1'b0; ar_pend = 1'b0; end
      if (do_w && (aw_fire || w_fire) && !aw_pend && !w_pend)
        checkOutput("bvalid_after_commit", 32'(S_AXI_BVALID), 32'd1);
      cyc++;
      if (do_w && aw_pend && cyc == w_lead) S_AXI_AWVALID = 1'b1;
    end
    if (aw_pend || w_pend || ar_pend) begin
      checkOutput("handshake_timeout", 32'd1, 32'd0);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while ((b_q.size() != 0 || r_q.size() != 0 || wr_q.size() != 0) && cyc < 200) begin
      @(posedge ACLK); #1;
      S_AXI_BREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      S_AXI_RREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    if (cyc >= 200) begin
      checkOutput("drain_timeout", 32'(b_q.size() + r_q.size() + wr_q.size()), 32'd0);
      b_q.delete(); r_q.delete(); wr_q.delete();
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
  endtask

  initial begin
    logic [4:0]  ra, wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          op;
    model_reset();

    #2 ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    checkOutput("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    checkOutput("rst_wready", 32'(S_AXI_WREADY), 32'd0);
    checkOutput("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    checkOutput("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    checkOutput("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    checkOutput("rst_rdata", S_AXI_RDATA, 32'd0);
    checkOutput("rst_cfg_wr", 32'(cfg_wr_o), 32'd0);
    checkOutput("rst_cfg_idx", 32'(cfg_idx_o), 32'd0);
    check_cfg("rst");
    ARESETN = 1'b1;
    checkOutput("arready_before_edge", 32'(S_AXI_ARREADY), 32'd0);
    @(posedge ACLK); #1;
    checkOutput("awready_after_rst", 32'(S_AXI_AWREADY), 32'd1);
    checkOutput("wready_after_rst", 32'(S_AXI_WREADY), 32'd1);
    checkOutput("arready_after_rst", 32'(S_AXI_ARREADY), 32'd1);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(i * 4), 32'(i + 1), 4'hF, 0, 1'b0, 5'h0);
      drain();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 5'h0, 32'h0, 4'h0, 0, 1'b1, 5'(i * 4));
      drain();
    end
    check_cfg("basic");

    applyStimulus(1'b1, 5'h08, 32'hAABBCCDD, 4'b0101, 0, 1'b0, 5'h0);
    drain();
    checkOutput("strobe_merge", cfg2_o, 32'h00BB00DD);
    applyStimulus(1'b1, 5'h08, 32'h11111111, 4'b0000, 0, 1'b0, 5'h0);
    drain();
    checkOutput("strb0_keep", cfg2_o, 32'h00BB00DD);

    S_AXI_BREADY = 1'b0;
    applyStimulus(1'b1, 5'h04, 32'h12345678, 4'hF, 3, 1'b0, 5'h0);
    repeat (5) begin
      @(negedge ACLK);
      checkOutput("bp_bvalid", 32'(S_AXI_BVALID), 32'd1);
      checkOutput("bp_awready", 32'(S_AXI_AWREADY), 32'd0);
      checkOutput("bp_wready", 32'(S_AXI_WREADY), 32'd0);
    end
    drain();
    checkOutput("skew_write", cfg1_o, 32'h12345678);

    applyStimulus(1'b1, 5'h00, 32'h55, 4'hF, 0, 1'b1, 5'h00);
    drain();
    applyStimulus(1'b0, 5'h0, 32'h0, 4'h0, 0, 1'b1, 5'h00);
    drain();

    applyStimulus(1'b0, 5'h0, 32'h0, 4'h0, 0, 1'b1, 5'h14);
    drain();
    applyStimulus(1'b1, 5'h10, 32'hDEADBEEF, 4'hF, 0, 1'b1, 5'h10);
    drain();
    check_cfg("post_status_write");

    // Reset arrives while an address is held and its data never came.
    @(posedge ACLK); #1;
    S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("partial_aw_ready", 32'(S_AXI_AWREADY), 32'd1);
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    #2 ARESETN = 1'b0;
    model_reset();
    #1;
    checkOutput("midrst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    check_cfg("midrst");
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (3) begin
      @(negedge ACLK);
      checkOutput("no_bvalid_after_rst", 32'(S_AXI_BVALID), 32'd0);
    end
    applyStimulus(1'b1, 5'h0C, 32'hCAFEF00D, 4'hF, 2, 1'b0, 5'h0);
    drain();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(($urandom_range(0, 3)) << 2), $urandom, 4'hF, 0, 1'b0, 5'h0);
      drain();
    end
    applyStimulus(1'b0, 5'h0, 32'h0, 4'h0, 0, 1'b1, 5'h10);
    drain();
    check_cfg("post_reset");

    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 2));
      wa = 5'($urandom_range(0, 7) << 2);
      ra = 5'($urandom_range(0, 7) << 2);
      wd = $urandom;
      ws = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      applyStimulus(op != 1, wa, wd, ws, int'($urandom_range(0, 2)), op != 0, ra);
      drain();
    end
    rand_ready = 1'b0;
    check_cfg("final");
    checkOutput("queues_empty", 32'(b_q.size() + r_q.size() + wr_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
